// File: rtl/sprite_pkg.sv
// Shared sprite-pipeline types: scan state encoding, default slot count, index-width helper.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } sprite_scan_state_t;

  localparam int SPRITE_NUM_DEFAULT = 256;

  // Index width for a slot count, never narrower than one bit.
  function automatic int sprite_idx_width(input int num);
    return (num <= 2) ? 1 : $clog2(num);
  endfunction

endpackage

// File: rtl/sprite_idx_wrap.sv
// Modulo-NUM_SPRITES index incrementer: purely combinational, zero latency.
// No handshake; the caller decides when the incremented value is taken.
module sprite_idx_wrap
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = SPRITE_NUM_DEFAULT,
  parameter int IDX_W       = sprite_idx_width(NUM_SPRITES)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_next
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_SPRITES - 1);

  assign idx_next = (idx == IDX_MAX) ? '0 : idx + 1'b1;

endmodule

// File: rtl/sprite_scan_counter.sv
// Sprite index sequencer over a wrapping inclusive range; first index one cycle after start, then one per cycle,
// holds while ready is low. SPRITE_SCAN_SKIP_EN adds active_mask: masked-off indices are skipped without a handshake.
module sprite_scan_counter
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = SPRITE_NUM_DEFAULT,
  localparam int IDX_W      = sprite_idx_width(NUM_SPRITES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [IDX_W-1:0]       first,
  input  logic [IDX_W-1:0]       last,
  input  logic                   ready,
`ifdef SPRITE_SCAN_SKIP_EN
  input  logic [NUM_SPRITES-1:0] active_mask,
`endif
  output logic [IDX_W-1:0]       sprite_num,
  output logic                   idx_valid,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W:0]         accepted
);

  localparam logic [IDX_W:0] NUM_EXT = (IDX_W+1)'(NUM_SPRITES);

  sprite_scan_state_t state_q, state_d;
  logic [IDX_W-1:0]   num_q, num_d, num_inc;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W:0]     acc_q, acc_d;
  logic [IDX_W-1:0]   first_red, last_red;
  logic               present, xfer, step;

  // Out-of-range range bounds are below 2*NUM_SPRITES, so one subtraction reduces them.
  assign first_red = ({1'b0, first} >= NUM_EXT) ? first - NUM_EXT[IDX_W-1:0] : first;
  assign last_red  = ({1'b0, last}  >= NUM_EXT) ? last  - NUM_EXT[IDX_W-1:0] : last;

`ifdef SPRITE_SCAN_SKIP_EN
  assign present = active_mask[num_q];
`else
  assign present = 1'b1;
`endif

  assign busy       = (state_q == SCAN);
  assign done       = (state_q == DONE);
  assign idx_valid  = busy && present;
  assign sprite_num = num_q;
  assign accepted   = acc_q;

  assign xfer = idx_valid && ready;
  // A masked-off index moves on without waiting for the downstream.
  assign step = xfer || (busy && !present);

  sprite_idx_wrap #(
    .NUM_SPRITES(NUM_SPRITES),
    .IDX_W      (IDX_W)
  ) u_wrap (
    .idx     (num_q),
    .idx_next(num_inc)
  );

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    last_d  = last_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          num_d   = first_red;
          last_d  = last_red;
          acc_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // The downstream saw the handshake, so it counts even when aborting.
        if (xfer && (acc_q != NUM_EXT)) acc_d = acc_q + 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (step) begin
          if (num_q == last_q) state_d = DONE;
          else                 num_d   = num_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      last_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_sprite_scan_counter.sv
// Bench for sprite_scan_counter: a 256-slot and a 40-slot instance checked every cycle against a range-walk model.
module tb_sprite_scan_counter;

  localparam int N0 = 256;
  localparam int N1 = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1, abort, ready;
  logic [7:0] first0, last0, num0;
  logic [5:0] first1, last1, num1;
  logic       vld0, vld1, busy0, busy1, done0, done1;
  logic [8:0] acc0;
  logic [6:0] acc1;
`ifdef SPRITE_SCAN_SKIP_EN
  logic [N0-1:0] mask0 = '1;
  logic [N1-1:0] mask1 = '1;
`endif

  sprite_scan_counter #(.NUM_SPRITES(N0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort),
    .first(first0), .last(last0), .ready(ready),
`ifdef SPRITE_SCAN_SKIP_EN
    .active_mask(mask0),
`endif
    .sprite_num(num0), .idx_valid(vld0), .busy(busy0), .done(done0), .accepted(acc0)
  );

  sprite_scan_counter #(.NUM_SPRITES(N1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .first(first1), .last(last1), .ready(ready),
`ifdef SPRITE_SCAN_SKIP_EN
    .active_mask(mask1),
`endif
    .sprite_num(num1), .idx_valid(vld1), .busy(busy1), .done(done1), .accepted(acc1)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model phases: 0 idle, 1 scanning, 2 done. Index = (first + pos) mod n, len = range size.
  int m_state[2] = '{0, 0};
  int m_num[2]   = '{0, 0};
  int m_acc[2]   = '{0, 0};
  int m_pos[2]   = '{0, 0};
  int m_len[2]   = '{1, 1};
  int m_first[2] = '{0, 0};

  always @(posedge clk) begin : model
    int n, f, l;
    bit st;
    for (int d = 0; d < 2; d++) begin
      n  = (d == 0) ? N0 : N1;
      f  = (d == 0) ? int'(first0) : int'(first1);
      l  = (d == 0) ? int'(last0)  : int'(last1);
      st = (d == 0) ? start0 : start1;
      if (rst) begin
        m_state[d] <= 0;
        m_num[d]   <= 0;
        m_acc[d]   <= 0;
        m_pos[d]   <= 0;
      end else begin
        case (m_state[d])
          0: if (st && !abort) begin
            m_first[d] <= f % n;
            m_len[d]   <= ((l % n) - (f % n) + n) % n + 1;
            m_pos[d]   <= 0;
            m_num[d]   <= f % n;
            m_acc[d]   <= 0;
            m_state[d] <= 1;
          end
          1: begin
            if (ready) m_acc[d] <= (m_acc[d] + 1 > n) ? n : m_acc[d] + 1;
            if (abort) m_state[d] <= 0;
            else if (ready) begin
              if (m_pos[d] + 1 == m_len[d]) m_state[d] <= 2;
              else begin
                m_pos[d] <= m_pos[d] + 1;
                m_num[d] <= (m_first[d] + m_pos[d] + 1) % n;
              end
            end
          end
          default: m_state[d] <= 0;
        endcase
      end
    end
  end

  task automatic check_dut(input int d, input int num, input bit vld, input bit bsy,
                           input bit dn, input int acc);
    bit ok;
    ok = (num == m_num[d]) && (vld == (m_state[d] == 1)) && (bsy == (m_state[d] == 1)) &&
         (dn == (m_state[d] == 2)) && (acc == m_acc[d]);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL model_u%0d cyc=%0d: got num=%0d vld=%0d busy=%0d done=%0d acc=%0d, need num=%0d vld=%0d busy=%0d done=%0d acc=%0d",
               d, cyc, num, vld, bsy, dn, acc, m_num[d], m_state[d] == 1, m_state[d] == 1,
               m_state[d] == 2, m_acc[d]);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_dut(0, int'(num0), vld0, busy0, done0, int'(acc0));
      check_dut(1, int'(num1), vld1, busy1, done1, int'(acc1));
    end
  end

  // Transfer log and hold counter for the literal checks.
  int q0[$];
  int q1[$];
  int last_xfer0 = 0;
  int hold5 = 0;
  always @(negedge clk) begin
    if (vld0 && ready) begin
      q0.push_back(int'(num0));
      last_xfer0 = cyc;
    end
    if (vld1 && ready) q1.push_back(int'(num1));
    if (vld0 && num0 == 8'd5) hold5++;
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, need %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if ((d == 0) ? done0 : done1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    int mism;
    int exp_b[6];
    int exp_c[3];
    exp_b = '{37, 38, 39, 0, 1, 2};
    exp_c = '{5, 6, 7};
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; ready = 1'b1;
    first0 = '0; last0 = '0; first1 = '0; last1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_num0", int'(num0), 0);
    chk("reset_vld_busy_done0", {vld0, busy0, done0}, 0);
    chk("reset_acc0", int'(acc0), 0);
    chk("reset_vld_busy_done1", {vld1, busy1, done1}, 0);
    cmp_en = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);

    // Full 256-entry scan with ready held high.
    q0.delete();
    first0 = 8'd0; last0 = 8'd255; start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    wait_done(0, 300, ok);
    chk("A_done_seen", ok, 1);
    chk("A_count", q0.size(), 256);
    mism = 0;
    foreach (q0[i]) if (q0[i] != i) mism++;
    chk("A_seq_mismatches", mism, 0);
    chk("A_done_latency", cyc - last_xfer0, 1);
    chk("A_accepted", int'(acc0), 256);
    @(negedge clk);
    chk("A_done_one_cycle", done0, 0);

    // Wrapping range on the 40-slot instance.
    q1.delete();
    first1 = 6'd37; last1 = 6'd2; start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    wait_done(1, 50, ok);
    chk("B_done_seen", ok, 1);
    chk("B_count", q1.size(), 6);
    mism = 0;
    foreach (q1[i]) if (i < 6 && q1[i] != exp_b[i]) mism++;
    chk("B_seq_mismatches", mism, 0);
    chk("B_accepted", int'(acc1), 6);

    // Start during DONE is ignored; the following IDLE start reduces 45..47 to 5..7.
    q1.delete();
    first1 = 6'd45; last1 = 6'd47; start1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("B_start_in_done_ignored", busy1, 0);
    tick(1);
    start1 = 1'b0;
    @(negedge clk);
    chk("B_restart_busy", busy1, 1);
    chk("B_reduced_first", int'(num1), 5);
    wait_done(1, 20, ok);
    chk("B2_done_seen", ok, 1);
    mism = (q1.size() == 3) ? 0 : 1;
    foreach (q1[i]) if (i < 3 && q1[i] != exp_c[i]) mism++;
    chk("B2_seq_mismatches", mism, 0);
    chk("B2_accepted", int'(acc1), 3);

    // Single index with three stalled cycles.
    tick(1);
    ready = 1'b0; first0 = 8'd5; last0 = 8'd5;
    hold5 = 0;
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    tick(3);
    ready = 1'b1;
    wait_done(0, 10, ok);
    chk("C_done_seen", ok, 1);
    chk("C_hold_cycles", hold5, 4);
    chk("C_accepted", int'(acc0), 1);

    // Abort at index 10 with a simultaneous transfer; start/first changes mid-scan ignored.
    tick(1);
    first0 = 8'd0; last0 = 8'd20; start0 = 1'b1;
    tick(1);
    first0 = 8'd100;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vld0 && num0 == 8'd10) begin
        ok = 1'b1;
        break;
      end
    end
    chk("D_reached_10", ok, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start0 = 1'b0;
    @(negedge clk);
    chk("D_busy_after_abort", busy0, 0);
    chk("D_no_done", done0, 0);
    chk("D_accepted", int'(acc0), 11);
    mism = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0) mism++;
    end
    chk("D_no_late_done", mism, 0);

    // Start together with abort in IDLE is ignored.
    start0 = 1'b1; abort = 1'b1;
    tick(1);
    start0 = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("E_start_with_abort", busy0, 0);

    // Reset mid-scan, then a fresh wrapping scan.
    tick(1);
    first0 = 8'd0; last0 = 8'd255; start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    tick(5);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("F_rst_num", int'(num0), 0);
    chk("F_rst_flags", {vld0, busy0, done0}, 0);
    chk("F_rst_acc", int'(acc0), 0);
    rst = 1'b0;
    q0.delete();
    first0 = 8'd250; last0 = 8'd3; start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    wait_done(0, 30, ok);
    chk("F_done_seen", ok, 1);
    chk("F_count", q0.size(), 10);
    chk("F_first_idx", (q0.size() > 0) ? q0[0] : -1, 250);
    chk("F_last_idx", (q0.size() > 9) ? q0[9] : -1, 3);
    chk("F_accepted", int'(acc0), 10);

    tick(3);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
